// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/PC-update sequencer.
//   state_e   : sequencer states
//   pc_src_e  : PC mux source select (encoding matches the pc_src port)
//   OP_*      : RV32I major opcodes that redirect the PC
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_IDLE = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_RD    = 3'd2,
        ST_EXEC       = 3'd3,
        ST_UPDATE     = 3'd4,
        ST_FAULT      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PCS_PLUS4 = 2'b00,
        PCS_OFFS  = 2'b01,
        PCS_ALU   = 2'b10
    } pc_src_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/pc_src_decode.sv
// Combinational PC source decode from opcode and branch outcome.
//   opcode   in  7   instruction bits [6:0]
//   br_taken in  1   branch condition result
//   pc_src_c out     selected PC source
module pc_src_decode
    import pc_seq_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       br_taken,
    output pc_src_e    pc_src_c
);

    always_comb begin
        pc_src_c = PCS_PLUS4;
        case (opcode)
            OP_BRANCH: pc_src_c = br_taken ? PCS_OFFS : PCS_PLUS4;
            OP_JAL:    pc_src_c = PCS_OFFS;
            OP_JALR:   pc_src_c = PCS_ALU;
            default:   pc_src_c = PCS_PLUS4;
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch / PC-update sequencer for the RV32I core.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap JALR targets with bit 1 set.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   imem_req/gnt/rvalid/rdata   instruction memory handshake
//   instr, instr_valid          held instruction for execute
//   ex_done, br_taken           execute completion and branch outcome
//   jalr_target                 JALR target (misalignment check only)
//   pc_we, pc_src               one-cycle PC write strobe and source select
//   fetch_fault                 sticky watchdog fault
//   trap                        misaligned-target pulse
//   instret                     retired instruction count
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic                 ex_done,
    input  logic                 br_taken,
    input  logic [31:0]          jalr_target,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 fetch_fault,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    state_e          state;
    logic [WD_W-1:0] wdog;
    pc_src_e         dec_src_c;
    logic            misalign_c;
    logic            wdog_hit_c;

    pc_src_decode u_pc_src_decode (
        .opcode   (instr[6:0]),
        .br_taken (br_taken),
        .pc_src_c (dec_src_c)
    );

    // This cycle's wait would be the TIMEOUT_CYC-th one.
    assign wdog_hit_c = (wdog == WD_W'(TIMEOUT_CYC - 1));

`ifdef PC_MISALIGN_TRAP_EN
    // JALR clears bit 0 itself, so only bit 1 makes the target misaligned.
    assign misalign_c = (dec_src_c == PCS_ALU) && jalr_target[1];
`else
    logic unused_jalr_target;
    assign misalign_c         = 1'b0;
    assign unused_jalr_target = ^jalr_target;
`endif

    // Sequencer with registered outputs; pc_we/pc_src/trap default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET_IDLE;
            wdog        <= '0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_we       <= 1'b0;
            pc_src      <= 2'b00;
            fetch_fault <= 1'b0;
            trap        <= 1'b0;
            instret     <= '0;
        end else begin
            pc_we  <= 1'b0;
            pc_src <= 2'(PCS_PLUS4);
            trap   <= 1'b0;
            case (state)
                ST_RESET_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    wdog     <= '0;
                end
                ST_FETCH: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        wdog     <= '0;
                        if (imem_rvalid) begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= ST_EXEC;
                        end else begin
                            state <= ST_WAIT_RD;
                        end
                    end else if (wdog_hit_c) begin
                        imem_req    <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= ST_FAULT;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_WAIT_RD: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end else if (wdog_hit_c) begin
                        fetch_fault <= 1'b1;
                        state       <= ST_FAULT;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        instr_valid <= 1'b0;
                        pc_we       <= 1'b1;
                        state       <= ST_UPDATE;
                        if (misalign_c) begin
                            trap <= 1'b1;
                        end else begin
                            pc_src  <= 2'(dec_src_c);
                            instret <= instret + INSTRET_W'(1);
                        end
                    end
                end
                ST_UPDATE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    wdog     <= '0;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_RESET_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed cases plus randomized fetches
// against an opcode-level reference model. Honors PC_MISALIGN_TRAP_EN.
module tb_pc_seq_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] jalr_target = '0;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        fetch_fault;
    logic        trap;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int model_ret = 0;
    int cyc = 0;
    logic prev_we = 1'b0;

    pc_seq_ctrl #(.TIMEOUT_CYC(TMO), .INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .ex_done(ex_done), .br_taken(br_taken), .jalr_target(jalr_target),
        .pc_we(pc_we), .pc_src(pc_src), .fetch_fault(fetch_fault), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Invariants between PC writes: source idle, no trap, no back-to-back strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!pc_we) begin
                check("src_idle", 64'(pc_src), 64'd0);
                check("trap_idle", 64'(trap), 64'd0);
            end
            if (prev_we) check("we_b2b", 64'(pc_we), 64'd0);
        end
        prev_we = pc_we && rst_n;
    end

    // Reference: expected PC source, trap and retire for one instruction.
    function automatic void model(input logic [31:0] w, input logic br, input logic [31:0] tgt,
                                  output int src, output bit trp);
        trp = 1'b0;
        if (w[6:0] == 7'h63)      src = br ? 1 : 0;
        else if (w[6:0] == 7'h6F) src = 1;
        else if (w[6:0] == 7'h67) src = 2;
        else                      src = 0;
`ifdef PC_MISALIGN_TRAP_EN
        if (src == 2 && tgt[1]) begin
            src = 0;
            trp = 1'b1;
        end
`else
        if (tgt[1] === 1'bx) trp = 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; ex_done = 1'b0;
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_we", 64'(pc_we), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);
        check("rst_ret", 64'(instret), 64'd0);
        model_ret = 0;
        rst_n = 1'b1;
    endtask

    // One full instruction: fetch with gd gnt-wait cycles, rvalid rd cycles after gnt
    // (0 = same cycle), ex_done after ed EXEC cycles; ex_done noise while fetching.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic [31:0] tgt,
                             input int gd, input int rd, input int ed);
        int n;
        int src;
        bit trp;
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        check("req_seen", 64'(imem_req), 64'd1);
        for (int i = 0; i < gd; i++) begin
            ex_done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_gnt = 1'b1;
        imem_rvalid = (rd == 0);
        imem_rdata = (rd == 0) ? w : $urandom;
        ex_done = (rd == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_gnt = 1'b0;
        if (rd > 0) begin
            imem_rvalid = 1'b0;
            for (int i = 0; i < rd - 1; i++) begin
                imem_rdata = $urandom;
                ex_done = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            imem_rvalid = 1'b1; imem_rdata = w; ex_done = 1'b0;
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        check("valid", 64'(instr_valid), 64'd1);
        check("instr", 64'(instr), 64'(w));
        check("req_drop", 64'(imem_req), 64'd0);
        repeat (ed) @(negedge clk);
        ex_done = 1'b1; br_taken = br; jalr_target = tgt;
        @(negedge clk);
        ex_done = 1'b0; br_taken = 1'($urandom_range(0, 1)); jalr_target = $urandom;
        model(w, br, tgt, src, trp);
        if (!trp) model_ret++;
        check("pc_we", 64'(pc_we), 64'd1);
        check("pc_src", 64'(pc_src), 64'(src));
        check("trap", 64'(trap), 64'(trp));
        check("instret", 64'(instret), 64'(model_ret));
        check("valid_clr", 64'(instr_valid), 64'd0);
    endtask

    logic [31:0] ops [6] = '{32'h0000_0013, 32'h0020_8463, 32'h0080_006F,
                             32'h0000_80E7, 32'h0000_00B3, 32'h00C0_0063};

    initial begin
        int c0;
        int n;
        logic [31:0] w;

        // Case 1: immediate gnt/rvalid, pc_we visible in the 4th cycle after release.
        do_reset();
        c0 = cyc;
        run_instr(32'h0000_0013, 1'b0, 32'h0, 0, 0, 0);
        check("lat_min", 64'(cyc - c0), 64'd3);

        // Cases 2-3: branch taken/not, JAL, JALR aligned.
        run_instr(32'h0020_8463, 1'b1, 32'h0, 1, 2, 1);
        run_instr(32'h0020_8463, 1'b0, 32'h0, 0, 1, 0);
        run_instr(32'h0080_006F, 1'b0, 32'h0, 2, 0, 2);
        run_instr(32'h0000_80E7, 1'b0, 32'h100, 0, 3, 0);

        // Case 6: misaligned and bit0-only JALR targets.
        run_instr(32'h0000_80E7, 1'b0, 32'h102, 0, 0, 0);
        run_instr(32'h0000_80E7, 1'b0, 32'h101, 1, 1, 1);

        // Randomized stream within the watchdog budget.
        for (int k = 0; k < 40; k++) begin
            w = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) w = $urandom;
            run_instr(w, 1'($urandom_range(0, 1)), $urandom,
                      $urandom_range(0, TMO - 1), $urandom_range(0, TMO), $urandom_range(0, 3));
        end

        // Case 4: gnt never arrives -> fault after TMO request cycles.
        do_reset();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        check("tmo_req_cycles", 64'(n), 64'(TMO));
        check("tmo_fault", 64'(fetch_fault), 64'd1);
        for (int i = 0; i < 8; i++) begin
            imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
            ex_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("fault_no_we", 64'(pc_we), 64'd0);
            check("fault_no_req", 64'(imem_req), 64'd0);
        end
        do_reset();

        // Watchdog in WAIT_RD: gnt then no rvalid.
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("wrd_not_yet", 64'(fetch_fault), 64'd0);
        @(negedge clk);
        check("wrd_fault", 64'(fetch_fault), 64'd1);

        // Case 5: reset in WAIT_RD, rvalid during RESET_IDLE is dropped.
        do_reset();
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("rst_ign_instr", 64'(instr), 64'd0);
        check("rst_ign_valid", 64'(instr_valid), 64'd0);
        check("rst_refetch", 64'(imem_req), 64'd1);
        model_ret = 0;
        run_instr(32'h0080_006F, 1'b0, 32'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
